// File: rtl/adc_dc_cal_if.sv
// Sample/control bundle between the ADC input latch, the DC calibrator and
// the delta-sigma sub-top.
interface adc_dc_cal_if #(
    parameter int W = 16
);
    logic         cal_start;
    logic         bypass;
    logic [W-1:0] din1;
    logic [W-1:0] din2;
    logic [W-1:0] dout1;
    logic [W-1:0] dout2;
    logic [W-1:0] off1;
    logic [W-1:0] off2;
    logic         cal_busy;
    logic         cal_done;

    modport master (
        output cal_start, bypass, din1, din2,
        input  dout1, dout2, off1, off2, cal_busy, cal_done
    );

    modport slave (
        input  cal_start, bypass, din1, din2,
        output dout1, dout2, off1, off2, cal_busy, cal_done
    );
endinterface

// File: rtl/adc_dc_cal.sv
// DC-offset calibration for two signed ADC channels: averages 2^LOG2N samples
// after a settle window, then subtracts the averages (saturating) from the live streams.
module adc_dc_cal #(
    parameter int W        = 16,
    parameter int LOG2N    = 10,
    parameter int SETTLE   = 64,
    parameter bit AUTO_CAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    adc_dc_cal_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    localparam int AW = W + LOG2N;
    localparam int CW = (($clog2(SETTLE) > LOG2N) ? $clog2(SETTLE) : LOG2N) + 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);
    localparam logic [CW-1:0] ACCUM_LOAD  = CW'((1 << LOG2N) - 1);
    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};

    state_t          state_r;
    state_t          state_next_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_next_s;
    logic [AW-1:0]   acc1_r;
    logic [AW-1:0]   acc2_r;
    logic [W-1:0]    off1_r;
    logic [W-1:0]    off2_r;
    logic [W-1:0]    dout1_r;
    logic [W-1:0]    dout2_r;
    logic            cal_busy_r;
    logic            cal_done_r;
    logic            auto_pend_r;
    logic            acc_clr_s;
    logic            acc_en_s;
    logic            load_s;

    // Saturating a - b, computed one bit wider so the overflow is visible.
    function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        d = {a[W-1], a} - {b[W-1], b};
        if (d[W] != d[W-1]) begin
            sat_sub = d[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sat_sub = d[W-1:0];
        end
    endfunction

    // Calibration sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, window counter and datapath strobes.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        acc_clr_s    = 1'b0;
        acc_en_s     = 1'b0;
        load_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.cal_start || auto_pend_r) begin
                    state_next_s = ST_SETTLE;
                    cnt_next_s   = SETTLE_LOAD;
                    acc_clr_s    = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_next_s = ST_ACCUM;
                    cnt_next_s   = ACCUM_LOAD;
                end else begin
                    cnt_next_s   = cnt_r - CNT_ONE;
                end
            end
            ST_ACCUM: begin
                acc_en_s = 1'b1;
                if (cnt_r == CNT_ZERO) begin
                    state_next_s = ST_UPDATE;
                end else begin
                    cnt_next_s   = cnt_r - CNT_ONE;
                end
            end
            ST_UPDATE: begin
                load_s       = 1'b1;
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Counter, status flags and the one-shot auto-start flag re-armed only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= CNT_ZERO;
            cal_busy_r  <= 1'b0;
            cal_done_r  <= 1'b0;
            auto_pend_r <= AUTO_CAL;
        end else begin
            cnt_r       <= cnt_next_s;
            cal_busy_r  <= (state_next_s != ST_IDLE);
            cal_done_r  <= load_s;
            auto_pend_r <= 1'b0;
        end
    end

    // Sign-extended accumulators; wide enough that 2^LOG2N samples never overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc1_r <= {AW{1'b0}};
            acc2_r <= {AW{1'b0}};
        end else if (acc_clr_s) begin
            acc1_r <= {AW{1'b0}};
            acc2_r <= {AW{1'b0}};
        end else if (acc_en_s) begin
            acc1_r <= acc1_r + {{LOG2N{bus.din1[W-1]}}, bus.din1};
            acc2_r <= acc2_r + {{LOG2N{bus.din2[W-1]}}, bus.din2};
        end
    end

    // Taking the upper W bits is the arithmetic shift by LOG2N (floor average).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off1_r <= {W{1'b0}};
            off2_r <= {W{1'b0}};
        end else if (load_s) begin
            off1_r <= acc1_r[AW-1:LOG2N];
            off2_r <= acc2_r[AW-1:LOG2N];
        end
    end

    // Live correction path, active in every state with the offsets currently held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout1_r <= {W{1'b0}};
            dout2_r <= {W{1'b0}};
        end else begin
            dout1_r <= bus.bypass ? bus.din1 : sat_sub(bus.din1, off1_r);
            dout2_r <= bus.bypass ? bus.din2 : sat_sub(bus.din2, off2_r);
        end
    end

    assign bus.dout1    = dout1_r;
    assign bus.dout2    = dout2_r;
    assign bus.off1     = off1_r;
    assign bus.off2     = off2_r;
    assign bus.cal_busy = cal_busy_r;
    assign bus.cal_done = cal_done_r;
endmodule

// File: doc/adc_dc_cal.md
# adc_dc_cal

- Sequences a DC-offset calibration of the two signed 16-bit ADC channels and applies the measured offsets to the live sample streams.
- Sits between the ADC input latch (signed, left-justified 16-bit samples) and the delta-sigma sub-top.
- On request, or automatically after reset, it waits out a settle window and averages 2^LOG2N samples per channel.
- It then loads the averages as offsets, which are subtracted from every later sample with saturation.

## Interface
Parameters:
- W, 16, sample width (signed, two's complement)
- LOG2N, 10, log2 of samples averaged per calibration
- SETTLE, 64, cycles discarded after start before accumulation (≥1)
- AUTO_CAL, 1, 1 = start a calibration automatically on the first cycle after reset release

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- cal_start  in  1  calibration request, sampled only in IDLE
- bypass  in  1  1 = dout passes din unmodified (offset not applied)
- din1, din2  in  W  signed ADC samples, one per clk
- dout1, dout2  out  W  signed corrected samples, registered
- off1, off2  out  W  signed current offsets
- cal_busy  out  1  calibration in progress
- cal_done  out  1  one-cycle pulse when new offsets take effect

## Operation
- States: IDLE, SETTLE, ACCUM, UPDATE.
- IDLE -> SETTLE:
  - on cal_start=1 at an edge;
  - or, with AUTO_CAL=1, at the first edge after rst deasserts (one-shot flag, re-armed only by rst).
- SETTLE -> ACCUM after SETTLE edges (down-counter).
- ACCUM -> UPDATE after 2^LOG2N edges. acc1 += din1 and acc2 += din2 each edge. acc1 and acc2 are cleared on SETTLE entry.
- UPDATE -> IDLE on the next edge. That edge also loads off1 = acc1 >>> LOG2N and off2 = acc2 >>> LOG2N and asserts cal_done.
- Accumulators are W+LOG2N bits signed, so no overflow is possible. The shift is arithmetic, so results are floor-rounded (e.g. sum −1 → −1).
- Datapath runs every cycle in all states. It uses the offset currently in off1/off2; old offsets remain in effect during calibration.
- dout = bypass ? din : sat(din − off).
  - Subtraction is done at W+1 bits.
  - sat clamps to [−2^(W−1), 2^(W−1)−1].
- cal_start while cal_busy=1 is ignored; no queuing.
- Reset values: state IDLE, off1=off2=0, dout1=dout2=0, cal_busy=0, cal_done=0, accumulators 0, counters 0.
- Reset asserted mid-calibration aborts immediately: offsets return to 0 and no cal_done is issued. With AUTO_CAL=1, a fresh calibration starts after release.

## Timing
- Let E0 be the edge at which the start is taken.
- cal_busy = 1 from E0 through E(SETTLE+N). It reads 0 after E(SETTLE+N+1), where N = 2^LOG2N.
- Samples accumulated are those present at edges E(SETTLE+1) … E(SETTLE+N).
- off1/off2 change and cal_done = 1 for exactly one cycle after edge E(SETTLE+N+1).
- dout uses the new offset from edge E(SETTLE+N+2) onward, one cycle after off is visible.
- din → dout latency is 1 clk, and the same in bypass.
- cal_start asserted in the same cycle cal_done is high is accepted, since the state is IDLE. It starts a new calibration at that edge.

## Test plan
Run with LOG2N=4, SETTLE=8, AUTO_CAL=0, W=16.
- **Offset measurement:** din1=640, din2=−37 constant, pulse cal_start → cal_done pulses at E25 (SETTLE+16+1); off1=640, off2=−37; afterwards dout1=0, dout2=0, cal_busy low.
- **Rounding:** din1 alternates +1/−1 → off1=0. din2 = −1 for 1 of 16 accumulated samples and 0 otherwise → off2=−1 (floor). Settle samples set to 5000 are excluded from the result.
- **Saturation:** off1=−100 from a prior cal, din1=32767 → dout1=32767. off1=+100, din1=−32768 → dout1=−32768. bypass=1 → dout1=din1 one cycle later.
- **Busy handling:** second cal_start pulses during SETTLE and ACCUM → ignored, exactly one cal_done. A start in the cal_done cycle → second calibration begins, cal_busy is high the next cycle.
- **Reset mid-ACCUM:** assert rst asynchronously between clock edges → off, dout, cal_busy and cal_done all 0 before the next edge; no cal_done after release.
- **AUTO_CAL=1:** release rst with din1=300 → calibration starts without cal_start; cal_done at E25 after release, off1=300.
